hd63701_timer: RTL and testbench
================================

HD63701_TIMER -- requirements
Module: HD63701_TIMER

Interface
REQ-001 Parameter BASE, default 16'h0008, is the bus address of TCSR; the timer occupies BASE..BASE+6.
REQ-002 CLK  input  1  core clock; all state updates on rising edge.
REQ-003 RSTn  input  1  asynchronous active-low reset.
REQ-004 AD  input  16  core address bus.
REQ-005 RW  input  1  core bus direction: 1=write, 0=read.
REQ-006 DI  input  8  write data from core.
REQ-007 DO  output  8  read data; 8'h00 when not selected.
REQ-008 CS  output  1  high when AD is in BASE..BASE+6.
REQ-009 TIN  input  1  asynchronous input-capture pin.
REQ-010 TOUT  output  1  output-compare pin.
REQ-011 IRQ  output  1  timer interrupt request, level, active-high.

Function
REQ-012 Register map, offset from BASE: 0 TCSR, 1 FRC high, 2 FRC low, 3 OCR high, 4 OCR low, 5 ICR high, 6 ICR low.
REQ-013 TCSR bits: 7 ICF, 6 OCF, 5 TOF (read-only flags); 4 EICI, 3 EOCI, 2 ETOI, 1 IEDG, 0 OLVL (read/write).
REQ-014 One access per CLK cycle with CS high; the access takes effect on that rising edge.
REQ-015 DO is combinational: selected register byte when CS=1 and RW=0, else 8'h00.
REQ-016 FRC increments by 1 every CLK; FFFF wraps to 0000 and sets TOF in the same edge.
REQ-017 Write of any data to FRC high loads FRC with 16'hFFF8; writes to FRC low are ignored.
REQ-018 Read of FRC high returns FRC[15:8] and latches FRC[7:0] into an 8-bit temp; read of FRC low returns the temp.
REQ-019 OCR high/low are independently byte-writable and readable.
REQ-020 Compare: when FRC equals OCR, set OCF and drive TOUT to OLVL on the same edge.
REQ-021 Compare is inhibited for the single cycle after any OCR byte write.
REQ-022 TIN is synchronised by two flops; capture edge is rising if IEDG=1, falling if IEDG=0.
REQ-023 On a detected edge: ICR loads current FRC and ICF sets; pin-to-capture latency is 3 CLK.
REQ-024 ICR is read-only; writes to offsets 5/6 are ignored.
REQ-025 Flag clear: reading TCSR while a flag is 1 arms that flag's clear.
REQ-026 Armed TOF clears on next read of FRC high; armed OCF clears on next write to OCR high or low; armed ICF clears on next read of ICR high; the arm bit drops with the clear.
REQ-027 A flag set event in the same cycle as its clear wins: flag stays 1, arm drops.
REQ-028 A flag-clearing access without a prior arming TCSR read has no effect on the flag.
REQ-029 TCSR write updates bits 4:0 only.
REQ-030 IRQ = (ICF & EICI) | (OCF & EOCI) | (TOF & ETOI), combinational from registers.
REQ-031 FRC write (REQ-017) and compare/overflow use the post-write value from the next cycle; no overflow flag is generated by the load itself.

Reset
REQ-032 RSTn low asynchronously sets FRC=0000, OCR=FFFF, ICR=0000, TCSR=00, temp=00, all arm bits=0, synchroniser flops=0, TOUT=0.
REQ-033 RSTn assertion mid-access aborts the access; no flag or register retains partial update.
REQ-034 FRC begins counting on the first rising CLK after RSTn deasserts.

Verification
REQ-035 Reset release, no access -> FRC reads 0000 after reset, reaches FFFF after 65535 cycles, then TOF=1; IRQ=0 with ETOI=0, IRQ=1 after writing TCSR=04.
REQ-036 With TOF=1: read TCSR, then read FRC high -> TOF=0; read FRC high without the TCSR read -> TOF stays 1.
REQ-037 OCR=0100, OLVL=1 -> TOUT=1 and OCF=1 on the edge FRC=0100; read TCSR, write OCR high 02 -> OCF=0, no compare on the next cycle.
REQ-038 IEDG=1, TIN rises at FRC=1230 -> ICR=1233 (3-cycle latency), ICF=1; falling edge ignored; read TCSR, read ICR high -> ICF=0.
REQ-039 FRC=1234: read FRC high returns 12; 5 cycles later read FRC low returns 34; write FRC high 00 -> FRC reads FFF8, TOF set 8 cycles later.
REQ-040 RSTn pulsed low with OCF=1 and TOUT=1 -> TCSR=00, TOUT=0, OCR=FFFF immediately, without a clock edge.

Source files
------------

// File: rtl/hd63701_timer.sv
// HD63701-style 16-bit free-running timer with output compare, input capture and flag interrupts.
// Latency: register accesses take effect on the access edge; DO, CS and IRQ are combinational; TIN to capture is 3 CLK.
// Backpressure: none; the core may issue one access per cycle and every access completes immediately.
module hd63701_timer #(
    parameter logic [15:0] BASE = 16'h0008
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [15:0] AD,
    input  logic        RW,
    input  logic [7:0]  DI,
    output logic [7:0]  DO,
    output logic        CS,
    input  logic        TIN,
    output logic        TOUT,
    output logic        IRQ
);

    logic [15:0] frc, ocr, icr, frc_next;
    logic [7:0]  frc_tmp;
    logic [4:0]  ctl;            // EICI, EOCI, ETOI, IEDG, OLVL
    logic        icf, ocf, tof;
    logic        icf_arm, ocf_arm, tof_arm;
    logic        tin_s1, tin_s2, tin_s3;
    logic        ocr_wr_d;
    logic [2:0]  off;
    logic        rd, wr;
    logic        rd_tcsr, wr_tcsr, rd_frch, wr_frch, wr_ocrh, wr_ocrl, rd_icrh;
    logic        tof_set, ocf_set, cap_edge, tof_clr, ocf_clr, icf_clr;

    assign CS  = (AD >= BASE) && (AD <= BASE + 16'd6);
    assign off = AD[2:0] - BASE[2:0];
    assign rd  = CS & ~RW;
    assign wr  = CS & RW;

    assign rd_tcsr = rd && (off == 3'd0);
    assign wr_tcsr = wr && (off == 3'd0);
    assign rd_frch = rd && (off == 3'd1);
    assign wr_frch = wr && (off == 3'd1);
    assign wr_ocrh = wr && (off == 3'd3);
    assign wr_ocrl = wr && (off == 3'd4);
    assign rd_icrh = rd && (off == 3'd5);

    // Compare and capture are referenced to the value FRC takes on this edge;
    // the FRC load edge itself neither compares nor overflows.
    assign frc_next = wr_frch ? 16'hFFF8 : frc + 16'd1;
    assign tof_set  = ~wr_frch && (frc == 16'hFFFF);
    assign ocf_set  = ~wr_frch && ~ocr_wr_d && (frc_next == ocr);
    assign cap_edge = ctl[1] ? (tin_s2 & ~tin_s3) : (~tin_s2 & tin_s3);

    assign tof_clr = tof_arm && rd_frch;
    assign ocf_clr = ocf_arm && (wr_ocrh || wr_ocrl);
    assign icf_clr = icf_arm && rd_icrh;

    assign IRQ = (icf & ctl[4]) | (ocf & ctl[3]) | (tof & ctl[2]);

    always_comb begin
        DO = 8'h00;
        if (rd) begin
            case (off)
                3'd0:    DO = {icf, ocf, tof, ctl};
                3'd1:    DO = frc[15:8];
                3'd2:    DO = frc_tmp;
                3'd3:    DO = ocr[15:8];
                3'd4:    DO = ocr[7:0];
                3'd5:    DO = icr[15:8];
                3'd6:    DO = icr[7:0];
                default: DO = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            frc      <= 16'h0000;
            ocr      <= 16'hFFFF;
            icr      <= 16'h0000;
            frc_tmp  <= 8'h00;
            ctl      <= 5'h00;
            icf      <= 1'b0;
            ocf      <= 1'b0;
            tof      <= 1'b0;
            icf_arm  <= 1'b0;
            ocf_arm  <= 1'b0;
            tof_arm  <= 1'b0;
            tin_s1   <= 1'b0;
            tin_s2   <= 1'b0;
            tin_s3   <= 1'b0;
            ocr_wr_d <= 1'b0;
            TOUT     <= 1'b0;
        end else begin
            frc      <= frc_next;
            tin_s1   <= TIN;
            tin_s2   <= tin_s1;
            tin_s3   <= tin_s2;
            ocr_wr_d <= wr_ocrh | wr_ocrl;

            if (wr_ocrh) ocr[15:8] <= DI;
            if (wr_ocrl) ocr[7:0]  <= DI;
            if (wr_tcsr) ctl       <= DI[4:0];
            if (rd_frch) frc_tmp   <= frc[7:0];
            if (cap_edge) icr      <= frc_next;
            if (ocf_set) TOUT      <= ctl[0];

            if (rd_tcsr) begin
                if (tof) tof_arm <= 1'b1;
                if (ocf) ocf_arm <= 1'b1;
                if (icf) icf_arm <= 1'b1;
            end

            // A set on the clearing edge keeps the flag but still consumes the arm.
            if (tof_set)      tof <= 1'b1;
            else if (tof_clr) tof <= 1'b0;
            if (tof_clr)      tof_arm <= 1'b0;

            if (ocf_set)      ocf <= 1'b1;
            else if (ocf_clr) ocf <= 1'b0;
            if (ocf_clr)      ocf_arm <= 1'b0;

            if (cap_edge)     icf <= 1'b1;
            else if (icf_clr) icf <= 1'b0;
            if (icf_clr)      icf_arm <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hd63701_timer.sv
// Directed bench for hd63701_timer: register-map vector table plus timed compare/capture/overflow/reset sequences.
module tb_hd63701_timer;

    localparam logic [15:0] BASE_A = 16'h0008;
    localparam logic [15:0] IDLE   = 16'h0000;

    logic        CLK, RSTn, RW, TIN;
    logic [15:0] AD;
    logic [7:0]  DI, DO;
    logic        CS, TOUT, IRQ;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc;

    hd63701_timer #(.BASE(BASE_A)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .AD   (AD),
        .RW   (RW),
        .DI   (DI),
        .DO   (DO),
        .CS   (CS),
        .TIN  (TIN),
        .TOUT (TOUT),
        .IRQ  (IRQ)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Edge count since reset release; FRC equals this until software loads FRC.
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        logic       rw;
        logic [2:0] off;
        logic [7:0] din;
        logic [7:0] exp;
        logic       chk;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // One bus access; entered and left at 1 time unit after a rising edge.
    task automatic acc(input logic rw, input logic [2:0] off, input logic [7:0] d, output logic [7:0] q);
        AD = BASE_A + {13'd0, off};
        RW = rw;
        DI = d;
        #1;
        q = DO;
        @(posedge CLK);
        #1;
        AD = IDLE;
        RW = 1'b0;
        DI = 8'h00;
    endtask

    task automatic rd(input logic [2:0] off, input logic [7:0] exp, input string nm);
        logic [7:0] q;
        acc(1'b0, off, 8'h00, q);
        chk(nm, {24'h0, q}, {24'h0, exp});
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] d);
        logic [7:0] q;
        acc(1'b1, off, d, q);
    endtask

    task automatic wait_until(input int unsigned n, input string nm);
        int guard;
        guard = 0;
        while (cyc < n && guard < 70000) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        chk(nm, cyc, n);
    endtask

    initial begin
        logic [7:0] q;
        tbl[0]  = '{1'b0, 3'd1, 8'h00, 8'h00, 1'b1};
        tbl[1]  = '{1'b0, 3'd2, 8'h00, 8'h00, 1'b1};
        tbl[2]  = '{1'b0, 3'd0, 8'h00, 8'h00, 1'b1};
        tbl[3]  = '{1'b0, 3'd3, 8'h00, 8'hFF, 1'b1};
        tbl[4]  = '{1'b0, 3'd4, 8'h00, 8'hFF, 1'b1};
        tbl[5]  = '{1'b0, 3'd5, 8'h00, 8'h00, 1'b1};
        tbl[6]  = '{1'b0, 3'd6, 8'h00, 8'h00, 1'b1};
        tbl[7]  = '{1'b1, 3'd5, 8'hAA, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 3'd5, 8'h00, 8'h00, 1'b1};
        tbl[9]  = '{1'b1, 3'd6, 8'h55, 8'h00, 1'b0};
        tbl[10] = '{1'b0, 3'd6, 8'h00, 8'h00, 1'b1};
        tbl[11] = '{1'b1, 3'd0, 8'hFF, 8'h00, 1'b0};
        tbl[12] = '{1'b0, 3'd0, 8'h00, 8'h1F, 1'b1};
        tbl[13] = '{1'b1, 3'd0, 8'hE2, 8'h00, 1'b0};
        tbl[14] = '{1'b0, 3'd0, 8'h00, 8'h02, 1'b1};
        tbl[15] = '{1'b1, 3'd4, 8'h00, 8'h00, 1'b0};
        tbl[16] = '{1'b0, 3'd3, 8'h00, 8'hFF, 1'b1};
        tbl[17] = '{1'b0, 3'd4, 8'h00, 8'h00, 1'b1};
        tbl[18] = '{1'b1, 3'd3, 8'h01, 8'h00, 1'b0};
        tbl[19] = '{1'b0, 3'd3, 8'h00, 8'h01, 1'b1};
        tbl[20] = '{1'b0, 3'd4, 8'h00, 8'h00, 1'b1};
        tbl[21] = '{1'b1, 3'd0, 8'h01, 8'h00, 1'b0};
        tbl[22] = '{1'b0, 3'd1, 8'h00, 8'h00, 1'b1};
        tbl[23] = '{1'b0, 3'd2, 8'h00, 8'h16, 1'b1};

        RSTn = 1'b0;
        AD   = IDLE;
        RW   = 1'b0;
        DI   = 8'h00;
        TIN  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_tout", {31'h0, TOUT}, 32'h0);
        chk("rst_irq", {31'h0, IRQ}, 32'h0);
        RSTn = 1'b1;

        // Register map after reset; entry k runs while FRC == k.
        for (int i = 0; i < 24; i++) begin
            acc(tbl[i].rw, tbl[i].off, tbl[i].din, q);
            if (tbl[i].chk) chk($sformatf("vec%0d", i), {24'h0, q}, {24'h0, tbl[i].exp});
        end

        // Output compare at OCR=0100 with OLVL=1, then clear and compare inhibit.
        wait_until(32'h00FF, "sync_ff");
        chk("tout_pre", {31'h0, TOUT}, 32'h0);
        rd(3'd0, 8'h01, "tcsr_pre_cmp");
        chk("tout_cmp", {31'h0, TOUT}, 32'h1);
        rd(3'd0, 8'h41, "tcsr_ocf");
        chk("irq_no_eoci", {31'h0, IRQ}, 32'h0);
        wr(3'd3, 8'h02);
        rd(3'd0, 8'h01, "ocf_clr");
        wait_until(32'h01FE, "sync_1fe");
        wr(3'd3, 8'h02);
        wait_until(32'h0200, "sync_200");
        rd(3'd0, 8'h01, "cmp_inhibit");
        chk("tout_hold", {31'h0, TOUT}, 32'h1);

        // Input capture on rising TIN, then FRC byte reads around it.
        wait_until(32'h0210, "sync_210");
        wr(3'd0, 8'h03);
        wait_until(32'h1230, "sync_1230");
        TIN = 1'b1;
        wait_until(32'h1232, "sync_1232");
        rd(3'd0, 8'h03, "icf_latency");
        rd(3'd0, 8'h83, "icf_set");
        rd(3'd1, 8'h12, "frch_1234");
        rd(3'd5, 8'h12, "icrh");
        rd(3'd6, 8'h33, "icrl");
        rd(3'd0, 8'h03, "icf_clr");
        TIN = 1'b0;
        wr(3'd0, 8'h07);
        rd(3'd2, 8'h34, "frcl_tmp");
        wait_until(32'h1240, "sync_1240");
        rd(3'd0, 8'h07, "fall_ignored");
        rd(3'd6, 8'h33, "icr_kept");

        // FRC load to FFF8 and overflow eight edges later.
        wr(3'd1, 8'h00);
        rd(3'd1, 8'hFF, "load_hi");
        rd(3'd2, 8'hF8, "load_lo");
        wait_until(32'h124A, "sync_124a");
        chk("irq_pre_ovf", {31'h0, IRQ}, 32'h0);
        wait_until(32'h124B, "sync_124b");
        chk("irq_ovf", {31'h0, IRQ}, 32'h1);
        rd(3'd1, 8'h00, "frch_noarm");
        chk("tof_noarm", {31'h0, IRQ}, 32'h1);
        rd(3'd0, 8'h27, "tcsr_tof");
        rd(3'd1, 8'h00, "frch_clr");
        chk("tof_clr_irq", {31'h0, IRQ}, 32'h0);
        rd(3'd0, 8'h07, "tof_clr");

        // Overflow landing on the arming clear: flag survives, arm is spent.
        wr(3'd1, 8'h00);
        wait_until(32'h1258, "sync_1258");
        rd(3'd0, 8'h27, "tof_again");
        wr(3'd1, 8'h00);
        wait_until(32'h1261, "sync_1261");
        rd(3'd1, 8'hFF, "frch_ffff");
        chk("set_wins", {31'h0, IRQ}, 32'h1);
        rd(3'd1, 8'h00, "frch_disarmed");
        chk("arm_dropped", {31'h0, IRQ}, 32'h1);
        rd(3'd0, 8'h27, "tcsr_setwins");

        // OCF and TOUT high, then asynchronous reset mid-cycle and across an access.
        wr(3'd3, 8'h00);
        wr(3'd4, 8'h20);
        wait_until(32'h1290, "sync_1290");
        rd(3'd0, 8'h67, "tcsr_pre_rst");
        AD = BASE_A;
        RW = 1'b0;
        #1;
        chk("tout_pre_rst", {31'h0, TOUT}, 32'h1);
        RSTn = 1'b0;
        #1;
        chk("rst_tcsr", {24'h0, DO}, 32'h00);
        chk("rst_tout_async", {31'h0, TOUT}, 32'h0);
        AD = BASE_A + 16'd3;
        #1;
        chk("rst_ocrh", {24'h0, DO}, 32'hFF);
        AD = BASE_A + 16'd4;
        #1;
        chk("rst_ocrl", {24'h0, DO}, 32'hFF);
        AD = BASE_A + 16'd1;
        #1;
        chk("rst_frch", {24'h0, DO}, 32'h00);
        AD = BASE_A;
        RW = 1'b1;
        DI = 8'hFF;
        @(posedge CLK);
        #1;
        AD = IDLE;
        RW = 1'b0;
        DI = 8'h00;
        RSTn = 1'b1;
        rd(3'd0, 8'h00, "aborted_wr");

        // Full 16-bit run from reset to overflow.
        wait_until(32'hFFFE, "sync_fffe");
        rd(3'd0, 8'h00, "tcsr_fffe");
        rd(3'd1, 8'hFF, "frch_ffff2");
        chk("irq_etoi0", {31'h0, IRQ}, 32'h0);
        rd(3'd2, 8'hFF, "frcl_ffff2");
        rd(3'd0, 8'h60, "tcsr_wrap");
        chk("tout_olvl0", {31'h0, TOUT}, 32'h0);
        wr(3'd0, 8'h04);
        chk("irq_etoi1", {31'h0, IRQ}, 32'h1);

        // Address decode edges, all inside one cycle.
        AD = BASE_A - 16'd1;
        #1;
        chk("cs_below", {31'h0, CS}, 32'h0);
        chk("do_unsel", {24'h0, DO}, 32'h00);
        AD = BASE_A + 16'd7;
        #1;
        chk("cs_above", {31'h0, CS}, 32'h0);
        AD = BASE_A + 16'd3;
        #1;
        chk("cs_ocrh", {31'h0, CS}, 32'h1);
        chk("do_ocrh", {24'h0, DO}, 32'hFF);
        AD = BASE_A + 16'd6;
        #1;
        chk("cs_top", {31'h0, CS}, 32'h1);
        AD = BASE_A;
        RW = 1'b1;
        #1;
        chk("do_on_write", {24'h0, DO}, 32'h00);
        AD = IDLE;
        RW = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
